// File: rtl/mm_pkg.sv
// Shared definitions for the MAC result unit: default sizes, FSM encoding
// and the flat PE index used for ld_mac/clear_mac and the accumulator bank.
package mm_pkg;

   localparam int MM_DIM    = 3;
   localparam int MM_DATA_W = 4;
   localparam int MM_ACC_W  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Row-major flat index of PE (i,j)
   function automatic int pe_idx(input int i, input int j);
      return i * MM_DIM + j;
   endfunction

endpackage

// File: rtl/mac_pe.sv
// Single MAC processing element: acc += w*x on ld, acc = 0 on clr (ld wins),
// hold otherwise or while frozen.
// Optional build macro MAC_SAT_EN: saturate at 2^ACC_W-1 instead of wrapping.
module mac_pe #(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] w,
   input  logic [DATA_W-1:0] x,
   input  logic              ld,
   input  logic              clr,
   input  logic              freeze,
   output logic [ACC_W-1:0]  acc
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [PROD_W-1:0] prod;

   assign prod = PROD_W'(w) * PROD_W'(x);
   assign acc  = acc_q;

`ifdef MAC_SAT_EN
   logic [SUM_W-1:0] sum_wide;
   assign sum_wide = SUM_W'(acc_q) + SUM_W'(prod);
`endif

   // Next accumulator value: accumulate, clear or hold
   always_comb begin
      acc_d = acc_q;
      if (!freeze) begin
         if (ld) begin
`ifdef MAC_SAT_EN
            if (sum_wide > SUM_W'({ACC_W{1'b1}}))
               acc_d = {ACC_W{1'b1}};
            else
               acc_d = sum_wide[ACC_W-1:0];
`else
            acc_d = ACC_W'(SUM_W'(acc_q) + SUM_W'(prod));
`endif
         end else if (clr) begin
            acc_d = '0;
         end
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

endmodule

// File: rtl/mac_result_unit.sv
// 3x3 outer-product MAC array with a row-major valid/ready drain of the
// row_w x col_x result sub-matrix.
// Optional build macro MAC_SAT_EN (passed through to mac_pe): saturating accumulators.
module mac_result_unit
   import mm_pkg::*;
#(
   parameter int DIM    = MM_DIM,
   parameter int DATA_W = MM_DATA_W,
   parameter int ACC_W  = MM_ACC_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_W-1:0]    data_w1,
   input  logic [DATA_W-1:0]    data_w2,
   input  logic [DATA_W-1:0]    data_w3,
   input  logic [DATA_W-1:0]    data_x1,
   input  logic [DATA_W-1:0]    data_x2,
   input  logic [DATA_W-1:0]    data_x3,
   input  logic [DIM*DIM-1:0]   ld_mac,
   input  logic [DIM*DIM-1:0]   clear_mac,
   input  logic                 unload_res,
   input  logic [1:0]           row_w,
   input  logic [1:0]           col_x,
   output logic [ACC_W-1:0]     res_data,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_last,
   output logic                 busy
);

   localparam int SEL_W = $clog2(DIM * DIM);

   state_e           state_q, state_d;
   logic             unload_prev_q;
   logic [1:0]       rows_q, rows_d, cols_q, cols_d;
   logic [1:0]       r_q, r_d, c_q, c_d;
   logic [ACC_W-1:0] res_data_q, res_data_d;
   logic             res_valid_q, res_valid_d;
   logic             res_last_q, res_last_d;

   logic [DATA_W-1:0] w_vec [DIM];
   logic [DATA_W-1:0] x_vec [DIM];
   logic [ACC_W-1:0]  acc   [DIM*DIM];

   logic unload_edge;
   logic acc_en;
   logic xfer;
   logic dims_zero;

   assign w_vec[0] = data_w1;
   assign w_vec[1] = data_w2;
   assign w_vec[2] = data_w3;
   assign x_vec[0] = data_x1;
   assign x_vec[1] = data_x2;
   assign x_vec[2] = data_x3;

   assign unload_edge = unload_res & ~unload_prev_q;
   assign xfer        = res_valid_q & res_ready;
   assign dims_zero   = (row_w == 2'd0) || (col_x == 2'd0);

   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
   assign res_last  = res_last_q;

   // PE array: PE(i,j) multiplies W row i by X column j
   for (genvar gi = 0; gi < DIM; gi++) begin : g_row
      for (genvar gj = 0; gj < DIM; gj++) begin : g_col
         mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk    (clk),
            .rst_n  (rst_n),
            .w      (w_vec[gi]),
            .x      (x_vec[gj]),
            .ld     (ld_mac[gi*DIM+gj]),
            .clr    (clear_mac[gi*DIM+gj]),
            .freeze (~acc_en),
            .acc    (acc[gi*DIM+gj])
         );
      end
   end

   // State and sequencer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         unload_prev_q <= 1'b0;
         rows_q        <= '0;
         cols_q        <= '0;
         r_q           <= '0;
         c_q           <= '0;
         res_data_q    <= '0;
         res_valid_q   <= 1'b0;
         res_last_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         unload_prev_q <= unload_res;
         rows_q        <= rows_d;
         cols_q        <= cols_d;
         r_q           <= r_d;
         c_q           <= c_d;
         res_data_q    <= res_data_d;
         res_valid_q   <= res_valid_d;
         res_last_q    <= res_last_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (unload_edge)
               state_d = dims_zero ? ST_DONE : ST_DRAIN;
            else if (state_q == ST_IDLE && |ld_mac)
               state_d = ST_ACCUM;
         end
         ST_DRAIN: if (xfer && res_last_q) state_d = ST_DONE;
         ST_DONE:  if (!unload_res)        state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: PEs only update while collecting operands
   always_comb begin
      acc_en = ((state_q == ST_IDLE) || (state_q == ST_ACCUM)) && !unload_res;
      busy   = (state_q == ST_DRAIN);
   end

   // Drain sequencer: latch dimensions, present one element, advance on transfer
   always_comb begin
      logic [1:0]       nr, nc;
      logic [SEL_W-1:0] sel;
      rows_d      = rows_q;
      cols_d      = cols_q;
      r_d         = r_q;
      c_d         = c_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
      nr          = r_q;
      nc          = c_q;
      sel         = '0;
      if (((state_q == ST_IDLE) || (state_q == ST_ACCUM)) && unload_edge) begin
         rows_d = row_w;
         cols_d = col_x;
         r_d    = '0;
         c_d    = '0;
         if (!dims_zero) begin
            res_valid_d = 1'b1;
            res_data_d  = acc[0];
            res_last_d  = (row_w == 2'd1) && (col_x == 2'd1);
         end
      end else if ((state_q == ST_DRAIN) && xfer) begin
         if (res_last_q) begin
            res_valid_d = 1'b0;
            res_data_d  = '0;
            res_last_d  = 1'b0;
         end else begin
            if (c_q == 2'(cols_q - 2'd1)) begin
               nr = 2'(r_q + 2'd1);
               nc = '0;
            end else begin
               nc = 2'(c_q + 2'd1);
            end
            sel         = SEL_W'(pe_idx(int'(nr), int'(nc)));
            r_d         = nr;
            c_d         = nc;
            res_data_d  = acc[sel];
            res_last_d  = (nr == 2'(rows_q - 2'd1)) && (nc == 2'(cols_q - 2'd1));
         end
      end
   end

endmodule

// File: tb/tb_mac_result_unit.sv
// Self-checking bench for mac_result_unit. A second instance with ACC_W=8
// shares all inputs to exercise overflow behaviour (wrap, or saturation when
// MAC_SAT_EN is defined).
module tb_mac_result_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
   logic [8:0] ld_mac, clear_mac;
   logic       unload_res, res_ready;
   logic [1:0] row_w, col_x;
   logic [9:0] res_data;
   logic [7:0] res_data8;
   logic       res_valid, res_last, busy;
   logic       res_valid8, res_last8, busy8;

   int nvec = 0;
   int nerr = 0;
   int m10 [9];
   int m8  [9];

   always #5 clk = ~clk;

   mac_result_unit dut (
      .clk(clk), .rst_n(rst_n),
      .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
      .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
      .ld_mac(ld_mac), .clear_mac(clear_mac), .unload_res(unload_res),
      .row_w(row_w), .col_x(col_x),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .res_last(res_last), .busy(busy)
   );

   mac_result_unit #(.ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
      .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
      .ld_mac(ld_mac), .clear_mac(clear_mac), .unload_res(unload_res),
      .row_w(row_w), .col_x(col_x),
      .res_data(res_data8), .res_valid(res_valid8), .res_ready(res_ready),
      .res_last(res_last8), .busy(busy8)
   );

   // Reference accumulation rule for an ACC_W-bit accumulator
   function automatic int upd(input int a, input int p, input int aw);
      int s, mx;
      s  = a + p;
      mx = (1 << aw) - 1;
`ifdef MAC_SAT_EN
      return (s > mx) ? mx : s;
`else
      return s & mx;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One operand cycle in IDLE/ACCUM; models follow the outer-product rule
   task automatic accum_cycle(input int w0, input int w1, input int w2,
                              input int x0, input int x1, input int x2,
                              input logic [8:0] ld, input logic [8:0] clr);
      int wv [3];
      int xv [3];
      wv = '{w0, w1, w2};
      xv = '{x0, x1, x2};
      data_w1 = 4'(w0); data_w2 = 4'(w1); data_w3 = 4'(w2);
      data_x1 = 4'(x0); data_x2 = 4'(x1); data_x3 = 4'(x2);
      ld_mac = ld; clear_mac = clr; unload_res = 1'b0;
      step();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            if (ld[i*3+j]) begin
               m10[i*3+j] = upd(m10[i*3+j], wv[i]*xv[j], 10);
               m8[i*3+j]  = upd(m8[i*3+j],  wv[i]*xv[j], 8);
            end else if (clr[i*3+j]) begin
               m10[i*3+j] = 0;
               m8[i*3+j]  = 0;
            end
         end
      ld_mac = '0; clear_mac = '0;
   endtask

   task automatic clear_all();
      accum_cycle(0, 0, 0, 0, 0, 0, 9'h000, 9'h1FF);
   endtask

   task automatic zero_models();
      for (int k = 0; k < 9; k++) begin
         m10[k] = 0;
         m8[k]  = 0;
      end
   endtask

   // Unload and collect rows x cols beats. Optional stall window, random
   // backpressure, or asynchronous reset before beat reset_at.
   task automatic drain(input int rows, input int cols, input int stall_at,
                        input int stall_len, input bit rand_ready, input int reset_at);
      int exp10 [$];
      int exp8  [$];
      int n, beat, cyc, stalled;
      logic       rdy, held;
      logic [9:0] prev_data;
      logic       prev_last;
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) begin
            exp10.push_back(m10[r*3+c]);
            exp8.push_back(m8[r*3+c]);
         end
      n = rows * cols;
      beat = 0; cyc = 0; stalled = 0; held = 1'b0;
      prev_data = '0; prev_last = 1'b0;
      row_w = 2'(rows); col_x = 2'(cols);
      unload_res = 1'b1; res_ready = 1'b0;
      step();
      row_w = 2'($urandom_range(0, 3)); col_x = 2'($urandom_range(0, 3));
      nvec++;
      if (res_valid !== 1'b1) begin
         nerr++;
         $display("FAIL first_beat_latency: res_valid=%b required 1", res_valid);
      end
      while (beat < n && cyc < 300) begin
         if (beat == reset_at) begin
            #2 rst_n = 1'b0;
            #1;
            nvec++;
            if (res_valid !== 1'b0 || res_data !== 10'd0 || res_last !== 1'b0 || busy !== 1'b0) begin
               nerr++;
               $display("FAIL async_reset_outputs: valid=%b data=%0d last=%b busy=%b required all 0",
                        res_valid, res_data, res_last, busy);
            end
            zero_models();
            unload_res = 1'b0; res_ready = 1'b0;
            step();
            rst_n = 1'b1;
            $display("reset asserted before beat %0d", beat);
            return;
         end
         if (held) begin
            nvec++;
            if (res_data !== prev_data || res_last !== prev_last) begin
               nerr++;
               $display("FAIL stall_hold: data=%0d last=%b required %0d %b",
                        res_data, res_last, prev_data, prev_last);
            end
         end
         nvec++;
         if (res_valid !== 1'b1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL drain_valid_busy: valid=%b busy=%b required 1 1 at beat %0d",
                     res_valid, busy, beat);
         end
         if (beat == stall_at && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end else if (rand_ready) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         res_ready = rdy;
         if (res_valid && rdy) begin
            nvec++;
            if (res_data !== 10'(exp10[beat]) || res_data8 !== 8'(exp8[beat]) ||
                res_last !== (beat == n - 1)) begin
               nerr++;
               $display("FAIL beat_%0d: data=%0d data8=%0d last=%b required %0d %0d %b",
                        beat, res_data, res_data8, res_last, exp10[beat], exp8[beat], beat == n - 1);
            end
            $display("beat %0d of %0d: data=%0d data8=%0d last=%b", beat, n, res_data, res_data8, res_last);
            beat++;
         end
         held = res_valid && !rdy;
         prev_data = res_data; prev_last = res_last;
         step();
         cyc++;
      end
      nvec++;
      if (beat != n) begin
         nerr++;
         $display("FAIL drain_timeout: got %0d beats required %0d", beat, n);
      end
      res_ready = 1'b0;
      nvec++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL drain_end: valid=%b busy=%b required 0 0", res_valid, busy);
      end
      unload_res = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      data_w1 = '0; data_w2 = '0; data_w3 = '0;
      data_x1 = '0; data_x2 = '0; data_x3 = '0;
      ld_mac = '0; clear_mac = '0; unload_res = 1'b0; res_ready = 1'b0;
      row_w = '0; col_x = '0;
      zero_models();
      step(); step();
      nvec++;
      if (res_valid !== 1'b0 || res_data !== 10'd0 || res_last !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL reset_state: valid=%b data=%0d last=%b busy=%b required all 0",
                  res_valid, res_data, res_last, busy);
      end
      rst_n = 1'b1;
      step();
      $display("reset released");
   endtask

   task automatic test_uniform();
      clear_all();
      for (int t = 0; t < 3; t++) accum_cycle(2, 2, 2, 3, 3, 3, 9'h1FF, 9'h000);
      drain(3, 3, -1, 0, 1'b0, -1);
   endtask

   task automatic test_2x2();
      clear_all();
      accum_cycle(1, 3, 0, 5, 6, 0, 9'h1FF, 9'h000);
      accum_cycle(2, 4, 0, 7, 8, 0, 9'h1FF, 9'h000);
      nvec++;
      if (m10[0] != 19 || m10[1] != 22 || m10[3] != 43 || m10[4] != 50) begin
         nerr++;
         $display("FAIL model_2x2: %0d %0d %0d %0d required 19 22 43 50", m10[0], m10[1], m10[3], m10[4]);
      end
      drain(2, 2, -1, 0, 1'b0, -1);
   endtask

   task automatic test_backpressure();
      clear_all();
      for (int t = 0; t < 3; t++)
         accum_cycle($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     9'h1FF, 9'h000);
      drain(3, 3, 3, 3, 1'b0, -1);
   endtask

   task automatic test_overflow();
      clear_all();
      for (int t = 0; t < 3; t++) accum_cycle(15, 15, 15, 15, 15, 15, 9'h1FF, 9'h000);
      nvec++;
`ifdef MAC_SAT_EN
      if (m10[8] != 675 || m8[8] != 255) begin
`else
      if (m10[8] != 675 || m8[8] != 163) begin
`endif
         nerr++;
         $display("FAIL model_overflow: %0d %0d", m10[8], m8[8]);
      end
      drain(3, 3, -1, 0, 1'b0, -1);
   endtask

   task automatic test_reset_mid();
      clear_all();
      for (int t = 0; t < 2; t++) accum_cycle(7, 9, 11, 13, 5, 3, 9'h1FF, 9'h000);
      drain(3, 3, -1, 0, 1'b0, 4);
      drain(3, 3, -1, 0, 1'b0, -1);
      clear_all();
      for (int t = 0; t < 3; t++) accum_cycle(4, 5, 6, 1, 2, 3, 9'h1FF, 9'h000);
      drain(3, 3, -1, 0, 1'b1, -1);
   endtask

   task automatic test_zero_dim();
      clear_all();
      accum_cycle(3, 1, 2, 2, 5, 1, 9'h1FF, 9'h000);
      row_w = 2'd0; col_x = 2'd3; unload_res = 1'b1;
      step();
      for (int t = 0; t < 4; t++) begin
         ld_mac = 9'h1FF; data_w1 = 4'd1;
         nvec++;
         if (res_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL zero_dim_no_drain: valid=%b busy=%b required 0 0", res_valid, busy);
         end
         step();
      end
      ld_mac = '0; unload_res = 1'b0;
      step();
      $display("zero-dim unload handled");
      drain(3, 3, -1, 0, 1'b0, -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         int ncyc;
         clear_all();
         ncyc = $urandom_range(1, 4);
         for (int t = 0; t < ncyc; t++)
            accum_cycle($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                        9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
         drain($urandom_range(1, 3), $urandom_range(1, 3), -1, 0, 1'b1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_2x2();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_zero_dim();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
